// File: rtl/data_mem_arbiter_if.sv
// Requester and data-memory bundle for the shared data memory arbiter.
// slave is the arbiter side; master is the requester/memory side.
interface data_mem_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_sign_mask;
  logic        a_ack;
  logic        a_err;
  logic [31:0] a_rdata;

  logic        b_req;
  logic        b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_sign_mask;
  logic        b_ack;
  logic        b_err;
  logic [31:0] b_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  logic        busy;
  logic        owner_b;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_sign_mask,
    output a_ack, a_err, a_rdata,
    input  b_req, b_we, b_addr, b_wdata, b_sign_mask,
    output b_ack, b_err, b_rdata,
    output mem_addr, mem_write_data, mem_memwrite,
    output mem_memread, mem_sign_mask,
    input  mem_read_data, mem_clk_stall,
    output busy, owner_b
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_sign_mask,
    input  a_ack, a_err, a_rdata,
    output b_req, b_we, b_addr, b_wdata, b_sign_mask,
    input  b_ack, b_err, b_rdata,
    input  mem_addr, mem_write_data, mem_memwrite,
    input  mem_memread, mem_sign_mask,
    output mem_read_data, mem_clk_stall,
    input  busy, owner_b
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer in front of the stalling data memory.
// Every output is a register loaded from its next-state value.
module data_mem_arbiter #(
  parameter bit          RR_EN      = 1'b1,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] LED_ADDR   = 32'h2000,
  parameter int          TIMEOUT    = 16
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    RESP
  } state_t;

  localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

  state_t      state, state_n;
  logic        rr_b, rr_b_n;
  logic        we, we_n;
  logic [4:0]  cnt, cnt_n;
  logic [31:0] addr, addr_n;
  logic [31:0] wdata, wdata_n;
  logic [3:0]  mask, mask_n;
  logic        rd_stb, rd_stb_n;
  logic        wr_stb, wr_stb_n;
  logic        a_ack, a_ack_n;
  logic        b_ack, b_ack_n;
  logic        a_err, a_err_n;
  logic        b_err, b_err_n;
  logic [31:0] a_rdata, a_rdata_n;
  logic [31:0] b_rdata, b_rdata_n;
  logic        busy, busy_n;
  logic        owner, owner_n;

  logic        pick_b;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_mask;
  logic        in_range;
  logic        fin;
  logic        fin_err;
  logic        fin_cap;

  always_comb begin
    pick_b = 1'b0;
    unique case (1'b1)
      bus.a_req && bus.b_req:  pick_b = RR_EN ? rr_b : 1'b0;
      bus.b_req && !bus.a_req: pick_b = 1'b1;
      default:                 pick_b = 1'b0;
    endcase
  end

  assign sel_we    = pick_b ? bus.b_we        : bus.a_we;
  assign sel_addr  = pick_b ? bus.b_addr      : bus.a_addr;
  assign sel_wdata = pick_b ? bus.b_wdata     : bus.a_wdata;
  assign sel_mask  = pick_b ? bus.b_sign_mask : bus.a_sign_mask;

  // LED_ADDR lives above the RAM span but must still reach the memory
  assign in_range = ((sel_addr >> ADDR_WIDTH) == 32'd0)
                 || (sel_addr == LED_ADDR);

  always_comb begin
    state_n   = state;
    rr_b_n    = rr_b;
    we_n      = we;
    cnt_n     = cnt;
    addr_n    = addr;
    wdata_n   = wdata;
    mask_n    = mask;
    owner_n   = owner;
    rd_stb_n  = 1'b0;
    wr_stb_n  = 1'b0;
    a_ack_n   = 1'b0;
    b_ack_n   = 1'b0;
    a_err_n   = 1'b0;
    b_err_n   = 1'b0;
    a_rdata_n = a_rdata;
    b_rdata_n = b_rdata;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_cap   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!bus.mem_clk_stall && (bus.a_req || bus.b_req)) begin
          owner_n = pick_b;
          rr_b_n  = !pick_b;
          we_n    = sel_we;
          addr_n  = sel_addr;
          wdata_n = sel_wdata;
          mask_n  = sel_mask;
          if (!in_range) begin
            state_n = RESP;
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_n  = ISSUE;
            rd_stb_n = !sel_we;
            wr_stb_n = sel_we;
          end
        end
      end
      ISSUE: begin
        state_n = WAIT_HI;
        cnt_n   = 5'd0;
      end
      WAIT_HI: begin
        if (bus.mem_clk_stall) begin
          state_n = WAIT_LO;
          cnt_n   = 5'd0;
        end else if (cnt == TO_LAST) begin
          state_n = RESP;
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      WAIT_LO: begin
        if (!bus.mem_clk_stall) begin
          state_n = RESP;
          fin     = 1'b1;
          fin_cap = !we;
        end else if (cnt == TO_LAST) begin
          state_n = RESP;
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // ack/err/rdata are loaded on the edge that enters RESP
    if (fin) begin
      if (owner_n) begin
        b_ack_n = 1'b1;
        b_err_n = fin_err;
        if (fin_err)      b_rdata_n = 32'd0;
        else if (fin_cap) b_rdata_n = bus.mem_read_data;
      end else begin
        a_ack_n = 1'b1;
        a_err_n = fin_err;
        if (fin_err)      a_rdata_n = 32'd0;
        else if (fin_cap) a_rdata_n = bus.mem_read_data;
      end
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_b    <= 1'b0;
      we      <= 1'b0;
      cnt     <= 5'd0;
      addr    <= 32'd0;
      wdata   <= 32'd0;
      mask    <= 4'd0;
      owner   <= 1'b0;
      rd_stb  <= 1'b0;
      wr_stb  <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_err   <= 1'b0;
      b_err   <= 1'b0;
      a_rdata <= 32'd0;
      b_rdata <= 32'd0;
      busy    <= 1'b0;
    end else begin
      rr_b    <= rr_b_n;
      we      <= we_n;
      cnt     <= cnt_n;
      addr    <= addr_n;
      wdata   <= wdata_n;
      mask    <= mask_n;
      owner   <= owner_n;
      rd_stb  <= rd_stb_n;
      wr_stb  <= wr_stb_n;
      a_ack   <= a_ack_n;
      b_ack   <= b_ack_n;
      a_err   <= a_err_n;
      b_err   <= b_err_n;
      a_rdata <= a_rdata_n;
      b_rdata <= b_rdata_n;
      busy    <= busy_n;
    end
  end

  assign bus.a_ack          = a_ack;
  assign bus.a_err          = a_err;
  assign bus.a_rdata        = a_rdata;
  assign bus.b_ack          = b_ack;
  assign bus.b_err          = b_err;
  assign bus.b_rdata        = b_rdata;
  assign bus.mem_addr       = addr;
  assign bus.mem_write_data = wdata;
  assign bus.mem_sign_mask  = mask;
  assign bus.mem_memread    = rd_stb;
  assign bus.mem_memwrite   = wr_stb;
  assign bus.busy           = busy;
  assign bus.owner_b        = owner;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters, each fronting
// a behavioural stalling memory.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_arbiter_if bus0 ();
  data_mem_arbiter_if bus1 ();

  data_mem_arbiter #(.RR_EN(1'b1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  data_mem_arbiter #(.RR_EN(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory 0: mode 0 normal, 1 never stalls, 2 stalls forever
  logic [31:0] mem0 [0:4095];
  logic        stall0 = 1'b0;
  logic [31:0] rd0 = 32'd0;
  int          cnt0 = 0;
  int          mode0 = 0;
  int          len0 = 2;

  assign bus0.mem_clk_stall = stall0;
  assign bus0.mem_read_data = rd0;

  always @(posedge clk) begin
    if ((bus0.mem_memread || bus0.mem_memwrite) && mode0 != 1) begin
      stall0 <= 1'b1;
      cnt0   <= (mode0 == 2) ? 0 : len0;
      if (bus0.mem_memwrite)
        mem0[bus0.mem_addr[13:2]] <= bus0.mem_write_data;
      else
        rd0 <= mem0[bus0.mem_addr[13:2]];
    end else if (cnt0 > 1) begin
      cnt0 <= cnt0 - 1;
    end else if (cnt0 == 1) begin
      cnt0   <= 0;
      stall0 <= 1'b0;
    end else if (mode0 != 2) begin
      stall0 <= 1'b0;
    end
  end

  logic        stall1 = 1'b0;
  logic [31:0] rd1 = 32'd0;
  int          cnt1 = 0;

  assign bus1.mem_clk_stall = stall1;
  assign bus1.mem_read_data = rd1;

  always @(posedge clk) begin
    if (bus1.mem_memread || bus1.mem_memwrite) begin
      stall1 <= 1'b1;
      cnt1   <= 2;
      rd1    <= 32'hC0DE0000 | bus1.mem_addr;
    end else if (cnt1 > 1) begin
      cnt1 <= cnt1 - 1;
    end else if (cnt1 == 1) begin
      cnt1   <= 0;
      stall1 <= 1'b0;
    end
  end

  // one transaction on dut0; latency counted in ticks from req
  task automatic run(input bit side, input bit we,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output int lat, output int first,
                     output int nrd, output int nwr,
                     output logic err, output logic [31:0] rd);
    lat = -1; first = -1; nrd = 0; nwr = 0; err = 1'b0; rd = 32'd0;
    if (side) begin
      bus0.b_we = we; bus0.b_addr = addr; bus0.b_wdata = wdata;
      bus0.b_req = 1'b1;
    end else begin
      bus0.a_we = we; bus0.a_addr = addr; bus0.a_wdata = wdata;
      bus0.a_req = 1'b1;
    end
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      tick();
      if (bus0.mem_memread)  nrd++;
      if (bus0.mem_memwrite) nwr++;
      if ((bus0.mem_memread || bus0.mem_memwrite) && first < 0)
        first = i;
      if (side ? bus0.b_ack : bus0.a_ack) begin
        lat = i;
        err = side ? bus0.b_err : bus0.a_err;
        rd  = side ? bus0.b_rdata : bus0.a_rdata;
      end
    end
    bus0.a_req = 1'b0;
    bus0.b_req = 1'b0;
    tick();
  endtask

  int          lat, first, nrd, nwr;
  logic        err;
  logic [31:0] rd;
  int          g0, g1;
  logic        own0 [4];
  logic        own1 [4];

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4096; i++) mem0[i] = 32'd0;
    mem0[32'h40 >> 2]  = 32'hDEADBEEF;
    mem0[32'h100 >> 2] = 32'h0BADF00D;
    mem0[32'hFFC >> 2] = 32'h55AA0FF0;
    bus0.a_req = 0; bus0.a_we = 0; bus0.a_addr = 0;
    bus0.a_wdata = 0; bus0.a_sign_mask = 4'hF;
    bus0.b_req = 0; bus0.b_we = 0; bus0.b_addr = 0;
    bus0.b_wdata = 0; bus0.b_sign_mask = 4'hF;
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = 0;
    bus1.a_wdata = 0; bus1.a_sign_mask = 4'hF;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = 0;
    bus1.b_wdata = 0; bus1.b_sign_mask = 4'hF;
    tick(); tick();
    chk("rst_busy",    32'(bus0.busy), 0);
    chk("rst_ack",     32'(bus0.a_ack | bus0.b_ack), 0);
    chk("rst_err",     32'(bus0.a_err | bus0.b_err), 0);
    chk("rst_rdata",   bus0.a_rdata | bus0.b_rdata, 0);
    chk("rst_addr",    bus0.mem_addr, 0);
    chk("rst_strobe",  32'(bus0.mem_memread | bus0.mem_memwrite), 0);
    chk("rst_owner",   32'(bus0.owner_b), 0);
    rst_n = 1'b1;
    tick();

    run(0, 0, 32'h1000, 0, lat, first, nrd, nwr, err, rd);
    chk("range_lat",    lat, 1);
    chk("range_err",    32'(err), 1);
    chk("range_strobe", nrd + nwr, 0);
    chk("range_rdata",  rd, 0);

    run(0, 1, 32'h2000, 32'hA5A5A5A5, lat, first, nrd, nwr, err, rd);
    chk("led_lat", lat, 5);
    chk("led_err", 32'(err), 0);
    chk("led_wr",  nwr, 1);

    run(0, 0, 32'hFFC, 0, lat, first, nrd, nwr, err, rd);
    chk("edge_err",   32'(err), 0);
    chk("edge_rdata", rd, 32'h55AA0FF0);

    run(0, 0, 32'h40, 0, lat, first, nrd, nwr, err, rd);
    chk("ld_lat",   lat, 5);
    chk("ld_rd",    nrd, 1);
    chk("ld_wr",    nwr, 0);
    chk("ld_err",   32'(err), 0);
    chk("ld_rdata", rd, 32'hDEADBEEF);

    run(1, 1, 32'h7C, 32'h12345678, lat, first, nrd, nwr, err, rd);
    chk("bst_lat",   lat, 5);
    chk("bst_wr",    nwr, 1);
    chk("bst_rd",    nrd, 0);
    chk("bst_err",   32'(err), 0);
    chk("bst_owner", 32'(bus0.owner_b), 1);

    run(1, 0, 32'h7C, 0, lat, first, nrd, nwr, err, rd);
    chk("bld_lat",   lat, 5);
    chk("bld_rd",    nrd, 1);
    chk("bld_rdata", rd, 32'h12345678);
    chk("a_hold",    bus0.a_rdata, 32'hDEADBEEF);

    // both sides held; pointer is at A after the B transactions
    bus0.a_we = 0; bus0.a_addr = 32'h100;
    bus0.b_we = 0; bus0.b_addr = 32'h104;
    bus1.a_we = 0; bus1.a_addr = 32'h100;
    bus1.b_we = 0; bus1.b_addr = 32'h104;
    bus0.a_req = 1; bus0.b_req = 1;
    bus1.a_req = 1; bus1.b_req = 1;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 150 && (bus0.a_req || bus0.b_req || bus1.a_req
         || bus1.b_req || bus0.busy || bus1.busy); i++) begin
      tick();
      if (bus0.mem_memread) begin
        if (g0 < 4) own0[g0] = bus0.owner_b;
        g0++;
      end
      if (bus1.mem_memread) begin
        if (g1 < 4) own1[g1] = bus1.owner_b;
        g1++;
      end
      if (bus0.a_ack && g0 >= 4) bus0.a_req = 0;
      if (bus0.b_ack && g0 >= 4) bus0.b_req = 0;
      if (bus1.a_ack && g1 >= 4) bus1.a_req = 0;
      if (bus1.b_ack && g1 >= 4) bus1.b_req = 0;
    end
    chk("rr_drain", 32'(bus0.busy | bus1.busy | bus0.a_req | bus0.b_req
                        | bus1.a_req | bus1.b_req), 0);
    chk("rr_g0", 32'(own0[0]), 0);
    chk("rr_g1", 32'(own0[1]), 1);
    chk("rr_g2", 32'(own0[2]), 0);
    chk("rr_g3", 32'(own0[3]), 1);
    chk("fix_g0", 32'(own1[0]), 0);
    chk("fix_g1", 32'(own1[1]), 0);
    chk("fix_g2", 32'(own1[2]), 0);
    chk("fix_g3", 32'(own1[3]), 0);
    chk("rr_a_rdata", bus0.a_rdata, 32'h0BADF00D);
    tick();

    mode0 = 1;
    run(0, 0, 32'h40, 0, lat, first, nrd, nwr, err, rd);
    chk("to_hi_lat",   lat, 18);
    chk("to_hi_err",   32'(err), 1);
    chk("to_hi_rdata", rd, 0);

    mode0 = 2;
    run(0, 0, 32'h40, 0, lat, first, nrd, nwr, err, rd);
    chk("to_lo_lat", lat, 19);
    chk("to_lo_err", 32'(err), 1);
    mode0 = 0;
    tick();
    chk("stall_clear", 32'(stall0), 0);

    len0 = 6;
    bus0.a_we = 0; bus0.a_addr = 32'h40; bus0.a_req = 1;
    tick(); tick(); tick();
    chk("mid_stall", 32'(stall0), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy",   32'(bus0.busy), 0);
    chk("mid_ack",    32'(bus0.a_ack), 0);
    chk("mid_addr",   bus0.mem_addr, 0);
    chk("mid_strobe", 32'(bus0.mem_memread), 0);
    len0 = 2;
    tick();
    chk("mid_noack", 32'(bus0.a_ack), 0);
    rst_n = 1'b1;
    run(0, 0, 32'h40, 0, lat, first, nrd, nwr, err, rd);
    chk("drain_first", first, 5);
    chk("drain_lat",   lat, 9);
    chk("drain_rd",    nrd, 1);
    chk("drain_err",   32'(err), 0);
    chk("drain_rdata", rd, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
